// File: rtl/logic_sweep_unit.sv
// -----------------------------------------------------------------------------
// logic_sweep_unit
//
// Bitwise logic unit with two ways to produce result beats:
//   * single operation: one {in_a, in_b, op} request gives one result beat
//     one cycle later.
//   * truth-table sweep: sweep_start latches op. The unit then emits every
//     {A,B} combination, from 0 to all-ones, as one beat each.
// The result register uses a valid/ready handshake. While the consumer stalls,
// the register holds its beat stable.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready single-operation request handshake
//   in_a, in_b        operands (WIDTH bits)
//   op                operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR,
//                     5 XNOR, 6 NOT A, 7 pass A
//   sweep_start       request an exhaustive sweep of op
//   out_valid/out_ready result beat handshake
//   out_a, out_b, out_op, out_y  contents of the current beat
//   busy              high while a sweep is in progress
//   sweep_done        one-cycle pulse after the final sweep beat is accepted
// -----------------------------------------------------------------------------
module logic_sweep_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             sweep_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_y,
  output logic             busy,
  output logic             sweep_done
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;        // {A,B} of the beat currently in the output register
  logic [CW-1:0]   cnt_next;
  logic            free;
  logic            sweep_accept;
  logic            single_accept;
  logic            beat_taken;
  logic            last_beat;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  assign free          = !out_valid || out_ready;
  assign busy          = (state == SWEEP);
  assign in_ready      = (state == IDLE) && !sweep_start && free;
  // A sweep request wins over a same-cycle single request because it drives in_ready low.
  assign sweep_accept  = (state == IDLE) && sweep_start && free;
  assign single_accept = in_valid && in_ready;
  assign beat_taken    = out_valid && out_ready;
  assign last_beat     = (cnt == {CW{1'b1}});
  assign cnt_next      = cnt + 1'b1;

  // NOTE: every variable assigned in an always_comb block gets a default first. Otherwise a missed branch infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sweep_accept) state_next = SWEEP;
      SWEEP:   if (beat_taken && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Output register and sweep counter. During a sweep, out_op keeps the latched
  // op, so later changes on the op input have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_op     <= '0;
      out_y      <= '0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (sweep_accept) begin
        cnt       <= '0;
        out_valid <= 1'b1;
        out_a     <= '0;
        out_b     <= '0;
        out_op    <= op;
        out_y     <= logic_op(op, '0, '0);
      end else if (single_accept) begin
        out_valid <= 1'b1;
        out_a     <= in_a;
        out_b     <= in_b;
        out_op    <= op;
        out_y     <= logic_op(op, in_a, in_b);
      end else if (state == SWEEP && beat_taken) begin
        if (last_beat) begin
          cnt        <= '0;
          out_valid  <= 1'b0;
          sweep_done <= 1'b1;
        end else begin
          cnt   <= cnt_next;
          out_a <= cnt_next[CW-1:WIDTH];
          out_b <= cnt_next[WIDTH-1:0];
          out_y <= logic_op(out_op, cnt_next[CW-1:WIDTH], cnt_next[WIDTH-1:0]);
        end
      end else if (beat_taken) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_sweep_unit
//
// Bench for logic_sweep_unit. It instantiates the unit twice:
//   u4  WIDTH=4  single operations, backpressure, 256-beat sweep,
//                reset in the middle of a sweep
//   u1  WIDTH=1  four-beat XOR sweep
// Expected values come from hand-computed tables and simple counters.
// -----------------------------------------------------------------------------
module tb_logic_sweep_unit;

  logic clk;
  logic rst_n;

  // WIDTH=4 instance signals
  logic       in_valid, in_ready, sweep_start, out_valid, out_ready, busy, sweep_done;
  logic [3:0] in_a, in_b, out_a, out_b, out_y;
  logic [2:0] op, out_op;

  // WIDTH=1 instance signals
  logic       in_valid1, in_ready1, sweep_start1, out_valid1, out_ready1, busy1, sweep_done1;
  logic [0:0] in_a1, in_b1, out_a1, out_b1, out_y1;
  logic [2:0] op1, out_op1;

  int checks = 0;
  int errors = 0;

  logic_sweep_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op), .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_y(out_y), .busy(busy), .sweep_done(sweep_done)
  );

  logic_sweep_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .op(op1), .sweep_start(sweep_start1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_a(out_a1), .out_b(out_b1),
    .out_op(out_op1), .out_y(out_y1), .busy(busy1), .sweep_done(sweep_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec_t;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } beat1_t;

  vec_t   vecs[11];
  beat1_t beats1[4];

  int  exp_beat;
  int  n_beats;
  int  n_done;
  bit  last;
  bit  finished;

  initial begin
    vecs[0]  = '{3'd0, 4'hC, 4'hA, 4'h8};
    vecs[1]  = '{3'd1, 4'hC, 4'hA, 4'hE};
    vecs[2]  = '{3'd2, 4'hC, 4'hA, 4'h6};
    vecs[3]  = '{3'd3, 4'hC, 4'hA, 4'h7};
    vecs[4]  = '{3'd4, 4'hC, 4'hA, 4'h1};
    vecs[5]  = '{3'd5, 4'hC, 4'hA, 4'h9};
    vecs[6]  = '{3'd6, 4'hC, 4'hA, 4'h3};
    vecs[7]  = '{3'd7, 4'hC, 4'hA, 4'hC};
    vecs[8]  = '{3'd1, 4'hF, 4'h0, 4'hF};
    vecs[9]  = '{3'd4, 4'h0, 4'h0, 4'hF};
    vecs[10] = '{3'd2, 4'h5, 4'h3, 4'h6};
    beats1[0] = '{1'b0, 1'b0, 1'b0};
    beats1[1] = '{1'b0, 1'b1, 1'b1};
    beats1[2] = '{1'b1, 1'b0, 1'b1};
    beats1[3] = '{1'b1, 1'b1, 1'b0};

    rst_n = 1'b1;
    in_valid = 0; sweep_start = 0; out_ready = 0; in_a = 0; in_b = 0; op = 0;
    in_valid1 = 0; sweep_start1 = 0; out_ready1 = 0; in_a1 = 0; in_b1 = 0; op1 = 0;

    // ---------------- reset state ----------------
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_y", out_y, 0);
    check("reset busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1);

    // ---------------- single ops, back-to-back ----------------
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d out_y", i), out_y, vecs[i].y);
      check($sformatf("vec%0d out_op", i), out_op, vecs[i].op);
      check($sformatf("vec%0d out_a/b", i), {out_a, out_b}, {vecs[i].a, vecs[i].b});
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", out_valid, 0);
    check("drain out_y holds", out_y, 4'h6);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; in_a = 4'hC; in_b = 4'hA;
    step();
    in_valid = 1'b1; op = 3'd1; in_a = 4'h3; in_b = 4'h3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d in_ready", i), in_ready, 0);
      check($sformatf("stall%0d beat", i), {out_valid, out_op, out_a, out_b, out_y},
            {1'b1, 3'd0, 4'hC, 4'hA, 4'h8});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release in_ready", in_ready, 1);
    step();
    check("release consumed", out_valid, 0);
    check("release in_ready after", in_ready, 1);

    // ---------------- sweep start beats in_valid, 256 beats, random stalls ----------------
    sweep_start = 1'b1; in_valid = 1'b1; op = 3'd2; in_a = 4'hF; in_b = 4'h1;
    #1;
    check("prio in_ready", in_ready, 0);
    step();
    check("prio busy", busy, 1);
    check("prio first beat", {out_valid, out_op, out_a, out_b, out_y}, {1'b1, 3'd2, 12'h000});
    exp_beat = 0; n_beats = 0; n_done = 0; finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = 1'($urandom_range(0, 1));
      sweep_start = 1'($urandom_range(0, 1));
      op          = 3'($urandom_range(0, 7));
      #1;
      if (busy && in_ready) check("sweep in_ready low", in_ready, 0);
      last = 1'b0;
      if (out_valid && out_ready) begin
        check($sformatf("sweep beat %0d", exp_beat), {out_op, out_a, out_b, out_y},
              {3'd2, 4'(exp_beat >> 4), 4'(exp_beat), 4'(exp_beat >> 4) ^ 4'(exp_beat)});
        last = (exp_beat == 255);
        exp_beat++;
        n_beats++;
      end
      step();
      if (sweep_done) n_done++;
      if (last) begin
        finished = 1'b1;
        check("sweep end state", {sweep_done, busy, out_valid}, 3'b100);
      end
    end
    sweep_start = 1'b0;
    check("sweep beat count", n_beats, 256);
    check("sweep done count", n_done, 1);
    // A single request is accepted in the sweep_done cycle.
    in_valid = 1'b1; op = 3'd0; in_a = 4'hC; in_b = 4'hA; out_ready = 1'b1;
    #1;
    check("done-cycle in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("done pulse width", sweep_done, 0);
    check("done-cycle single", {out_valid, out_y}, {1'b1, 4'h8});
    step();

    // ---------------- reset mid-sweep ----------------
    sweep_start = 1'b1; op = 3'd7;
    step();
    sweep_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("beat 10", {out_a, out_b, out_y}, {4'h0, 4'hA, 4'h0});
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {out_valid, out_a, out_b, out_op, out_y, busy, sweep_done}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post-reset idle", {busy, sweep_done, in_ready}, 3'b001);
    step();
    check("no done after abort", sweep_done, 0);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    check("restart first beat", {busy, out_valid, out_a, out_b}, {2'b11, 8'h00});
    step();
    check("restart second beat", {out_a, out_b}, 8'h01);

    // ---------------- WIDTH=1 sweep ----------------
    out_ready1 = 1'b1; sweep_start1 = 1'b1; op1 = 3'd2;
    step();
    sweep_start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w1 beat%0d", i), {out_valid1, busy1, out_a1, out_b1, out_y1},
            {2'b11, beats1[i].a, beats1[i].b, beats1[i].y});
      step();
    end
    check("w1 done", {sweep_done1, busy1, out_valid1}, 3'b100);
    step();
    check("w1 done pulse", sweep_done1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_sweep_unit.md
LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  single-operation request valid.
REQ-005 in_ready  output  1  unit accepts single-operation request this cycle.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 op  input  3  operation select, sampled on request or sweep acceptance.
REQ-009 sweep_start  input  1  request exhaustive truth-table sweep of op.
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  consumer accepts result beat.
REQ-012 out_a  output  WIDTH  A operand of current beat.
REQ-013 out_b  output  WIDTH  B operand of current beat.
REQ-014 out_op  output  3  op of current beat.
REQ-015 out_y  output  WIDTH  result of current beat.
REQ-016 busy  output  1  high while state is SWEEP.
REQ-017 sweep_done  output  1  one-cycle pulse after final sweep beat is accepted.

Function
REQ-018 op encoding, bitwise over WIDTH: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 pass A.
REQ-019 States IDLE and SWEEP; busy = (state == SWEEP).
REQ-020 Output register "free" = !out_valid || out_ready.
REQ-021 in_ready = (state == IDLE) && !sweep_start && free; combinational, no dependence on in_valid.
REQ-022 Single op: in_valid && in_ready at edge N -> at edge N: out_valid=1, out_a=in_a, out_b=in_b, out_op=op, out_y=f(op,in_a,in_b); latency 1 cycle; full throughput 1 beat/cycle when out_ready held high.
REQ-023 out_valid && !out_ready -> out_valid and all out_* held stable.
REQ-024 out_valid && out_ready with no new beat loaded -> out_valid falls next edge.
REQ-025 Sweep acceptance: state IDLE && sweep_start && free; op latched; state -> SWEEP; first beat loaded same edge with A=0, B=0.
REQ-026 sweep_start has priority over in_valid in the same cycle (in_ready low per REQ-021).
REQ-027 Sweep enumeration: 2*WIDTH-bit counter {A,B}, A in high half, increments by 1 per accepted beat, from 0 to all-ones; total 2^(2*WIDTH) beats, no skipped or repeated values.
REQ-028 Sweep beats obey REQ-022/REQ-023 handshake; next beat loaded on the edge its predecessor is accepted (back-to-back at out_ready=1).
REQ-029 Final beat (A=B=all-ones) accepted -> out_valid falls, state -> IDLE, sweep_done=1 for exactly the next cycle, counter cleared.
REQ-030 In SWEEP: sweep_start ignored; in_valid ignored (in_ready=0); op changes ignored.
REQ-031 A single-op request can be accepted in the cycle sweep_done is high.
REQ-032 Unused outputs: when out_valid=0, out_* hold last value (no X).

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, counter 0, out_valid 0, out_a/out_b/out_y 0, out_op 0, sweep_done 0, busy 0.
REQ-034 Reset mid-sweep aborts it; no sweep_done pulse; first edge after rst_n release is IDLE with in_ready=1 if sweep_start=0.
REQ-035 Deassertion of rst_n synchronised to clk by the integrator; block needs no internal synchroniser.

Verification
REQ-036 Reset: assert rst_n=0 mid-stream, no clock -> all outputs 0 immediately; in_ready=1 after release.
REQ-037 WIDTH=4 single op: in_a=4'hC, in_b=4'hA, op=0 -> next cycle out_y=4'h8; op=3 -> 4'h7; op=2 -> 4'h6; op=6 -> 4'h3.
REQ-038 Backpressure: out_ready=0 for 5 cycles after a beat -> in_ready=0, out_* unchanged; out_ready=1 -> beat consumed, in_ready=1.
REQ-039 WIDTH=1 sweep op=2, out_ready=1 -> beats (A,B,Y)=(0,0,0),(0,1,1),(1,0,1),(1,1,0) on consecutive cycles, then sweep_done one cycle, busy low.
REQ-040 Simultaneous sweep_start=1 and in_valid=1 in IDLE -> sweep accepted, request not accepted; WIDTH=4 sweep yields exactly 256 beats with random out_ready stalls.
REQ-041 rst_n pulsed low at beat 10 of a WIDTH=4 sweep -> no sweep_done; next sweep restarts at A=0, B=0.
